// File: rtl/thread_fetch_sched.sv
// Round-robin fetch scheduler for the two-thread stack pipeline: owns both thread PCs
// and halted flags, applies redirects/halts from later stages and pulses a squash to decode.
module thread_fetch_sched #(
    parameter int PC_W        = 16,
    parameter int T0_RESET_PC = 0,
    parameter int T1_RESET_PC = 1,
    parameter int PC_STEP     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_tid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt_valid,
    input  logic            halt_tid,
    output logic            fetch_valid,
    output logic            fetch_tid,
    output logic [PC_W-1:0] fetch_addr,
    output logic            squash_valid,
    output logic            squash_tid,
    output logic            halt
);

    localparam logic [PC_W-1:0] T0_PC   = PC_W'(T0_RESET_PC);
    localparam logic [PC_W-1:0] T1_PC   = PC_W'(T1_RESET_PC);
    localparam logic [PC_W-1:0] STEP_PC = PC_W'(PC_STEP);

    logic [PC_W-1:0] pc_r [2];
    logic [1:0]      halted_r;
    logic            rr_r;
    logic            squash_valid_r;
    logic            squash_tid_r;

    logic            sel_s;
    logic            any_run_s;
    logic            kill_s;
    logic            squash_ok_s;

    // Thread selection and zero-latency fetch address; a redirect to the selected thread kills its slot.
    always_comb begin
        any_run_s = ~(halted_r[0] & halted_r[1]);
        if (halted_r == 2'b00) begin
            sel_s = ~rr_r;
        end else if (halted_r[0]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        kill_s      = redirect_valid && (redirect_tid == sel_s) && !halted_r[sel_s];
        squash_ok_s = redirect_valid && !halted_r[redirect_tid]
                      && !(halt_valid && (halt_tid == redirect_tid));
        fetch_valid = !stall && any_run_s && !kill_s;
        fetch_tid   = sel_s;
        fetch_addr  = pc_r[sel_s];
    end

    // Per-thread PC/halted update (halt beats redirect beats sequential fetch), round-robin pointer, squash pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r[0]        <= T0_PC;
            pc_r[1]        <= T1_PC;
            halted_r       <= 2'b00;
            rr_r           <= 1'b1;
            squash_valid_r <= 1'b0;
            squash_tid_r   <= 1'b0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (halt_valid && (halt_tid == 1'(t))) begin
                    halted_r[t] <= 1'b1;
                end else if (redirect_valid && (redirect_tid == 1'(t)) && !halted_r[t]) begin
                    pc_r[t] <= redirect_pc;
                end else if (fetch_valid && (sel_s == 1'(t))) begin
                    pc_r[t] <= pc_r[t] + STEP_PC;
                end else begin
                    pc_r[t] <= pc_r[t];
                end
            end
            // A killed slot still counts as issued for fairness.
            if (!stall && any_run_s) begin
                rr_r <= sel_s;
            end else begin
                rr_r <= rr_r;
            end
            squash_valid_r <= squash_ok_s;
            squash_tid_r   <= redirect_tid;
        end
    end

    assign squash_valid = squash_valid_r;
    assign squash_tid   = squash_tid_r;
    assign halt         = halted_r[0] & halted_r[1];

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a thread-level behavioural model.
module tb_thread_fetch_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0;
    logic        redirect_valid = 1'b0, redirect_tid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_valid = 1'b0, halt_tid = 1'b0;
    logic        fetch_valid, fetch_tid, squash_valid, squash_tid, halt;
    logic [15:0] fetch_addr;

    thread_fetch_sched dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_addr(fetch_addr),
        .squash_valid(squash_valid), .squash_tid(squash_tid), .halt(halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: thread state plus the last thread that got an issue slot
    int  m_pc [2];
    bit  m_halted [2];
    int  m_last;
    bit  m_sqv;
    int  m_sqt;
    bit  m_known = 1'b0;

    // Values sampled in the most recent cycle
    logic        c_fv, c_tid, c_sqv, c_sqt, c_halt;
    logic [15:0] c_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit st, input bit rv, input int rt, input int rpc,
                       input bit hv, input int ht, input bit rs);
        int sel, nrun;
        bit efv;
        int npc [2];
        bit nhalt [2];
        @(negedge clk);
        reset = rs; stall = st;
        redirect_valid = rv; redirect_tid = rt[0]; redirect_pc = rpc[15:0];
        halt_valid = hv; halt_tid = ht[0];
        #1;
        c_fv = fetch_valid; c_tid = fetch_tid; c_addr = fetch_addr;
        c_sqv = squash_valid; c_sqt = squash_tid; c_halt = halt;
        nrun = int'(!m_halted[0]) + int'(!m_halted[1]);
        if (nrun == 2) sel = 1 - m_last;
        else sel = m_halted[0] ? 1 : 0;
        efv = !st && (nrun > 0) && !(rv && rt == sel && !m_halted[sel]);
        if (m_known) begin
            chk("fetch_valid", int'(c_fv), int'(efv));
            if (nrun > 0) begin
                chk("fetch_tid", int'(c_tid), sel);
                chk("fetch_addr", int'(c_addr), m_pc[sel]);
            end
            chk("halt", int'(c_halt), int'(m_halted[0] && m_halted[1]));
            chk("squash_valid", int'(c_sqv), int'(m_sqv));
            chk("squash_tid", int'(c_sqt), m_sqt);
        end
        @(posedge clk);
        if (rs) begin
            m_pc[0] = 0; m_pc[1] = 1;
            m_halted[0] = 1'b0; m_halted[1] = 1'b0;
            m_last = 1; m_sqv = 1'b0; m_sqt = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            for (int t = 0; t < 2; t++) begin
                npc[t] = m_pc[t];
                nhalt[t] = m_halted[t];
                if (hv && ht == t) nhalt[t] = 1'b1;
                else if (rv && rt == t && !m_halted[t]) npc[t] = rpc & 16'hFFFF;
                else if (efv && sel == t) npc[t] = (m_pc[t] + 2) % 65536;
            end
            m_sqv = rv && !m_halted[rt] && !(hv && ht == rt);
            m_sqt = rt;
            if (!st && nrun > 0) m_last = sel;
            for (int t = 0; t < 2; t++) begin
                m_pc[t] = npc[t];
                m_halted[t] = nhalt[t];
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        // Interleaved fetch after reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("seq_valid", int'(c_fv), 1);
            chk("seq_tid", int'(c_tid), i % 2);
            chk("seq_addr", int'(c_addr), i);
        end

        // Halt thread 0 after two fetches
        do_reset();
        idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("h0_tid", int'(c_tid), 1);
            chk("h0_addr", int'(c_addr), 3 + 2 * i);
            chk("h0_halt", int'(c_halt), 0);
        end

        // Redirect kills the tid1 slot and squashes
        do_reset();
        idle();
        cyc(1'b0, 1'b1, 1, 16'h0040, 1'b0, 0, 1'b0);
        chk("rd_kill", int'(c_fv), 0);
        idle();
        chk("rd_sqv", int'(c_sqv), 1);
        chk("rd_sqt", int'(c_sqt), 1);
        idle();
        chk("rd_tid", int'(c_tid), 1);
        chk("rd_addr", int'(c_addr), 16'h0040);
        idle();
        idle();
        chk("rd_addr2", int'(c_addr), 16'h0042);

        // Stall holds PCs and the round-robin pointer
        do_reset();
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
            chk("st_valid", int'(c_fv), 0);
        end
        idle();
        chk("st_tid", int'(c_tid), 0);
        chk("st_addr", int'(c_addr), 2);

        // Halt both threads; later redirect gives no squash
        do_reset();
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1, 1'b0);
        idle();
        chk("hb_halt", int'(c_halt), 1);
        chk("hb_valid", int'(c_fv), 0);
        cyc(1'b0, 1'b1, 0, 16'h0020, 1'b0, 0, 1'b0);
        idle();
        chk("hb_sqv", int'(c_sqv), 0);
        chk("hb_valid2", int'(c_fv), 0);

        // Mid-run reset with pc0 = 0x0010
        do_reset();
        cyc(1'b0, 1'b1, 0, 16'h0010, 1'b0, 0, 1'b0);
        idle();
        idle();
        chk("mr_pc0", int'(c_addr), 16'h0010);
        do_reset();
        idle();
        chk("mr_valid", int'(c_fv), 1);
        chk("mr_tid", int'(c_tid), 0);
        chk("mr_addr", int'(c_addr), 0);
        chk("mr_halt", int'(c_halt), 0);

        // PC wrap on thread 1
        do_reset();
        idle();
        cyc(1'b0, 1'b1, 1, 16'hFFFF, 1'b0, 0, 1'b0);
        idle();
        idle();
        chk("wr_addr", int'(c_addr), 16'hFFFF);
        idle();
        idle();
        chk("wr_tid", int'(c_tid), 1);
        chk("wr_addr2", int'(c_addr), 16'h0001);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit st, rv, hv, rs;
            int rpc;
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 6) == 0);
            hv  = ($urandom_range(0, 40) == 0);
            rs  = ($urandom_range(0, 80) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535));
            cyc(st, rv, int'($urandom_range(0, 1)), rpc, hv, int'($urandom_range(0, 1)), rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
